// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction-cache defaults, refill state encoding
// and the address-field width derivations.
package cpu_defs;

  localparam int ICACHE_ADDR_BITS  = 18;
  localparam int ICACHE_SETS       = 16;
  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_LINE_WORDS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } icache_state_e;

  function automatic int ic_ob(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int ic_ib(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int ic_tw(input int addr_bits, input int sets, input int line_words);
    return addr_bits - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  // A direct-mapped cache still needs a 1-bit pointer/victim signal.
  function automatic int ic_pw(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way_sel.sv
// Refill victim choice: lowest-index invalid way of the set, otherwise the
// set's round-robin pointer.
module icache_way_sel
  import cpu_defs::*;
#(
  parameter int WAYS = ICACHE_WAYS,
  localparam int PW  = ic_pw(WAYS)
) (
  input  logic [WAYS-1:0] set_valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   victim
);

  // Scanning downward lets the lowest invalid way win.
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) victim = PW'(w);
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with one outstanding line refill,
// hit-under-miss, and flush that can drop an in-flight line.
module icache_assoc
  import cpu_defs::*;
#(
  parameter int ADDR_BITS  = ICACHE_ADDR_BITS,
  parameter int SETS       = ICACHE_SETS,
  parameter int WAYS       = ICACHE_WAYS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [31:0]             pc_addr,
  input  logic                    pc_valid,
  input  logic                    flush,
  output logic                    hit,
  output logic [31:0]             ins_out,
  output logic                    busy,
  output logic                    mem_en,
  output logic [31:0]             addr_to_mem,
  input  logic                    mem_valid,
  input  logic [32*LINE_WORDS-1:0] ins_blk
);

  localparam int OB = ic_ob(LINE_WORDS);
  localparam int IB = ic_ib(SETS);
  localparam int TW = ic_tw(ADDR_BITS, SETS, LINE_WORDS);
  localparam int PW = ic_pw(WAYS);
  localparam int IW = (IB > 0) ? IB : 1;
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int LW = 32 * LINE_WORDS;
  localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

  icache_state_e   state_reg, state_next;
  logic            mem_en_reg, mem_en_next;
  logic [31:0]     addr_reg, addr_next;
  logic [PW-1:0]   victim_reg, victim_next, victim_sel;
  logic            fill_we;

  logic [SETS-1:0] valid_reg  [WAYS];
  logic [PW-1:0]   rr_ptr_reg [SETS];

  logic [IW-1:0]   pc_idx, fill_idx;
  logic [OW-1:0]   pc_off;
  logic [TW-1:0]   pc_tag, fill_tag;
  logic [WAYS-1:0] way_hit, set_valid;
  logic [31:0]     way_word [WAYS];

  // The fill target set/tag comes from the latched line address.
  assign pc_idx   = IW'((pc_addr >> (OB + 2)) % SETS);
  assign pc_off   = OW'((pc_addr >> 2) % LINE_WORDS);
  assign pc_tag   = TW'(pc_addr >> (IB + OB + 2));
  assign fill_idx = IW'((addr_reg >> (OB + 2)) % SETS);
  assign fill_tag = TW'(addr_reg >> (IB + OB + 2));

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TW-1:0] tag_mem  [SETS];
    logic [LW-1:0] data_mem [SETS];

    always_ff @(posedge clk) begin
      if (fill_we && victim_reg == PW'(gi)) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= ins_blk;
      end
    end

    assign set_valid[gi] = valid_reg[gi][pc_idx];
    assign way_hit[gi]   = set_valid[gi] && (tag_mem[pc_idx] == pc_tag);
    assign way_word[gi]  = data_mem[pc_idx][pc_off*32 +: 32];
  end

  icache_way_sel #(.WAYS(WAYS)) u_way_sel (
    .set_valid (set_valid),
    .rr_ptr    (rr_ptr_reg[pc_idx]),
    .victim    (victim_sel)
  );

  assign hit = (|way_hit) && !flush;

  always_comb begin
    ins_out = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w] && !flush) ins_out = ins_out | way_word[w];
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_en_next = mem_en_reg;
    addr_next   = addr_reg;
    victim_next = victim_reg;
    fill_we     = 1'b0;
    if (rst && rdy) begin
      case (state_reg)
        IDLE: if (pc_valid && !hit && !flush) begin
          state_next  = WAIT;
          mem_en_next = 1'b1;
          addr_next   = pc_addr & LINE_MASK;
          victim_next = victim_sel;
        end
        WAIT: if (mem_valid) begin
          state_next  = IDLE;
          mem_en_next = 1'b0;
          addr_next   = '0;
          fill_we     = !flush;
        end else if (flush) begin
          state_next  = DROP;
        end
        DROP: if (mem_valid) begin
          state_next  = IDLE;
          mem_en_next = 1'b0;
          addr_next   = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      mem_en_reg <= 1'b0;
      addr_reg   <= '0;
      victim_reg <= '0;
      for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr_reg[s] <= '0;
    end else begin
      state_reg  <= state_next;
      mem_en_reg <= mem_en_next;
      addr_reg   <= addr_next;
      victim_reg <= victim_next;
      if (rdy && flush) begin
        for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
        for (int s = 0; s < SETS; s++) rr_ptr_reg[s] <= '0;
      end else if (fill_we) begin
        for (int w = 0; w < WAYS; w++) begin
          if (victim_reg == PW'(w)) valid_reg[w][fill_idx] <= 1'b1;
        end
        rr_ptr_reg[fill_idx] <= (rr_ptr_reg[fill_idx] == PW'(WAYS - 1)) ? '0
                                : rr_ptr_reg[fill_idx] + 1'b1;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign mem_en      = mem_en_reg;
  assign addr_to_mem = addr_reg;

endmodule
